// File: rtl/btn_pkg.sv
// Shared button codes, controller state encoding and sizing helper
// for the button sequence memory game.
package btn_pkg;

    localparam logic [3:0] BTN_UP    = 4'd0;
    localparam logic [3:0] BTN_DOWN  = 4'd1;
    localparam logic [3:0] BTN_RIGHT = 4'd2;
    localparam logic [3:0] BTN_LEFT  = 4'd3;
    localparam logic [3:0] BTN_A     = 4'd4;
    localparam logic [3:0] BTN_B     = 4'd5;
    localparam logic [3:0] BTN_MAX   = BTN_B;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GROW,
        S_SHOW,
        S_GAP,
        S_INPUT,
        S_PASS,
        S_FAIL,
        S_WIN
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter that saturates at zero; done while count is zero.
// Ports: clk, rst, load/value (preset), count (decrement enable), done.
module cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         count,
    input  logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (count && cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/button_seq_ctrl.sv
// Memory game controller: grows a random button sequence, displays it,
// then checks the player's presses with an inactivity timeout.
// Ports: clk, rst, start, rand_in, btn_valid/btn_code in;
//        show_valid/show_code, busy, pass, fail, won, level out.
module button_seq_ctrl
    import btn_pkg::*;
#(
    parameter int MAX_LEN        = 16,
    parameter int SHOW_CYCLES    = 25_000_000,
    parameter int GAP_CYCLES     = 12_500_000,
    parameter int TIMEOUT_CYCLES = 250_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] rand_in,
    input  logic       btn_valid,
    input  logic [3:0] btn_code,
    output logic       show_valid,
    output logic [3:0] show_code,
    output logic       busy,
    output logic       pass,
    output logic       fail,
    output logic       won,
    output logic [4:0] level
);

    localparam int TMAX = max3(SHOW_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES);
    localparam int TW   = $clog2(TMAX + 1);
    localparam int IW   = $clog2(MAX_LEN);

    // Timer counts down to zero, so an interval of N cycles loads N-1.
    localparam logic [TW-1:0] SHOW_LD = TW'(SHOW_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LD  = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] TO_LD   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0]    LEN     = 5'(MAX_LEN);

    state_t        state, state_n;
    logic [4:0]    level_n;
    logic [4:0]    idx, idx_n;
    logic          wr;
    logic          tmr_load;
    logic          tmr_count;
    logic          tmr_done;
    logic [TW-1:0] tmr_val;
    logic [2:0]    seq [MAX_LEN];
    logic [2:0]    cur;

    assign cur = seq[idx[IW-1:0]];

    cycle_timer #(.W(TW)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (tmr_load),
        .count (tmr_count),
        .value (tmr_val),
        .done  (tmr_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            level <= '0;
            idx   <= '0;
        end else begin
            state <= state_n;
            level <= level_n;
            idx   <= idx_n;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            seq[level[IW-1:0]] <= rand_in[2:0];
        end
    end

    always_comb begin
        state_n  = state;
        level_n  = level;
        idx_n    = idx;
        wr       = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    level_n = '0;
                    state_n = S_GROW;
                end
            end
            S_GROW: begin
                if (rand_in <= BTN_MAX) begin
                    wr       = 1'b1;
                    level_n  = level + 5'd1;
                    idx_n    = '0;
                    tmr_load = 1'b1;
                    tmr_val  = SHOW_LD;
                    state_n  = S_SHOW;
                end
            end
            S_SHOW: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LD;
                    state_n  = S_GAP;
                end
            end
            S_GAP: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    if (idx < level - 5'd1) begin
                        idx_n   = idx + 5'd1;
                        tmr_val = SHOW_LD;
                        state_n = S_SHOW;
                    end else begin
                        idx_n   = '0;
                        tmr_val = TO_LD;
                        state_n = S_INPUT;
                    end
                end
            end
            S_INPUT: begin
                // A press on the expiry cycle wins over the timeout.
                if (btn_valid) begin
                    if (btn_code == {1'b0, cur}) begin
                        tmr_load = 1'b1;
                        tmr_val  = TO_LD;
                        if (idx == level - 5'd1) begin
                            state_n = S_PASS;
                        end else begin
                            idx_n = idx + 5'd1;
                        end
                    end else begin
                        state_n = S_FAIL;
                    end
                end else if (tmr_done) begin
                    state_n = S_FAIL;
                end
            end
            S_PASS: begin
                state_n = (level == LEN) ? S_WIN : S_GROW;
            end
            S_FAIL: begin
                state_n = S_IDLE;
            end
            S_WIN: begin
                if (start) begin
                    level_n = '0;
                    state_n = S_GROW;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign tmr_count  = (state == S_SHOW) || (state == S_GAP) ||
                        (state == S_INPUT);
    assign show_valid = (state == S_SHOW);
    assign show_code  = show_valid ? {1'b0, cur} : 4'd0;
    assign busy       = (state != S_IDLE);
    assign pass       = (state == S_PASS);
    assign fail       = (state == S_FAIL);
    assign won        = (state == S_WIN);

endmodule

// File: tb/tb_button_seq_ctrl.sv
// Directed bench for button_seq_ctrl with short intervals
// (show 4, gap 2, timeout 20, max length 3).
module tb_button_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] rand_in;
    logic       btn_valid;
    logic [3:0] btn_code;
    logic       show_valid;
    logic [3:0] show_code;
    logic       busy;
    logic       pass;
    logic       fail;
    logic       won;
    logic [4:0] level;

    int n_chk  = 0;
    int n_fail = 0;

    button_seq_ctrl #(
        .MAX_LEN        (3),
        .SHOW_CYCLES    (4),
        .GAP_CYCLES     (2),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rand_in    (rand_in),
        .btn_valid  (btn_valid),
        .btn_code   (btn_code),
        .show_valid (show_valid),
        .show_code  (show_code),
        .busy       (busy),
        .pass       (pass),
        .fail       (fail),
        .won        (won),
        .level      (level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered on the first SHOW cycle; leaves on the cycle after the gap.
    task automatic show_elem(input logic [3:0] code);
        int n;
        n = 0;
        while (show_valid && n < 10) begin
            chk("show_code", 32'(show_code), 32'(code));
            n++;
            tick();
        end
        chk("show_len", 32'(n), 4);
        chk("gap_blank", 32'(show_valid), 0);
        chk("gap_code", 32'(show_code), 0);
        tick();
        tick();
    endtask

    task automatic press(input logic [3:0] code);
        btn_valid = 1'b1;
        btn_code  = code;
        tick();
        btn_valid = 1'b0;
    endtask

    // Leaves on the first SHOW cycle of a fresh level-1 game.
    task automatic start_game(input logic [3:0] rnd);
        start   = 1'b1;
        rand_in = rnd;
        tick();
        chk("start_busy", 32'(busy), 1);
        chk("start_lvl0", 32'(level), 0);
        start = 1'b0;
        tick();
        chk("start_lvl1", 32'(level), 1);
        chk("start_show", 32'(show_valid), 1);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        rand_in   = 4'd0;
        btn_valid = 1'b0;
        btn_code  = 4'd0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_show", 32'(show_valid), 0);
        chk("rst_code", 32'(show_code), 0);
        chk("rst_pass", 32'(pass), 0);
        chk("rst_fail", 32'(fail), 0);
        chk("rst_won", 32'(won), 0);
        chk("rst_level", 32'(level), 0);

        start = 1'b1;
        tick();
        chk("rst_over_start", 32'(busy), 0);
        start     = 1'b0;
        rst       = 1'b0;
        btn_valid = 1'b1;
        tick();
        btn_valid = 1'b0;
        chk("idle_btn_ignored", 32'(busy), 0);

        // Round 1, then illegal random code held in GROW.
        start_game(4'd2);
        show_elem(4'd2);
        chk("input_busy", 32'(busy), 1);
        rand_in = 4'd7;
        press(4'd2);
        chk("r1_pass", 32'(pass), 1);
        chk("r1_nofail", 32'(fail), 0);
        tick();
        chk("r1_pass_pulse", 32'(pass), 0);
        chk("grow_level", 32'(level), 1);
        repeat (3) tick();
        chk("grow_hold_show", 32'(show_valid), 0);
        chk("grow_hold_lvl", 32'(level), 1);
        chk("grow_hold_busy", 32'(busy), 1);
        rand_in = 4'd4;
        tick();
        chk("r2_level", 32'(level), 2);
        show_elem(4'd2);
        show_elem(4'd4);
        press(4'd4);
        chk("wrong_fail", 32'(fail), 1);
        chk("wrong_nopass", 32'(pass), 0);
        tick();
        chk("wrong_idle", 32'(busy), 0);
        chk("wrong_pulse", 32'(fail), 0);
        chk("wrong_lvl_hold", 32'(level), 2);

        // Timeout with no press.
        start_game(4'd2);
        show_elem(4'd2);
        repeat (19) tick();
        chk("to_c20_nofail", 32'(fail), 0);
        chk("to_c20_busy", 32'(busy), 1);
        tick();
        chk("to_fail", 32'(fail), 1);
        tick();
        chk("to_idle", 32'(busy), 0);

        // Press on the expiry cycle, then play through to a win.
        start_game(4'd2);
        show_elem(4'd2);
        repeat (19) tick();
        press(4'd2);
        chk("late_pass", 32'(pass), 1);
        chk("late_nofail", 32'(fail), 0);
        rand_in = 4'd5;
        tick();
        tick();
        chk("w2_level", 32'(level), 2);
        show_elem(4'd2);
        show_elem(4'd5);
        press(4'd2);
        chk("w2_mid_pass", 32'(pass), 0);
        chk("w2_mid_fail", 32'(fail), 0);
        press(4'd5);
        chk("w2_pass", 32'(pass), 1);
        rand_in = 4'd0;
        tick();
        tick();
        chk("w3_level", 32'(level), 3);
        show_elem(4'd2);
        show_elem(4'd5);
        show_elem(4'd0);
        press(4'd2);
        press(4'd5);
        press(4'd0);
        chk("w3_pass", 32'(pass), 1);
        tick();
        chk("win_won", 32'(won), 1);
        chk("win_level", 32'(level), 3);
        chk("win_busy", 32'(busy), 1);
        tick();
        chk("win_hold", 32'(won), 1);
        start   = 1'b1;
        rand_in = 4'd1;
        tick();
        start = 1'b0;
        chk("restart_won", 32'(won), 0);
        chk("restart_lvl0", 32'(level), 0);
        tick();
        chk("restart_lvl1", 32'(level), 1);
        chk("restart_code", 32'(show_code), 1);

        // Reset in the middle of SHOW.
        tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_show", 32'(show_valid), 0);
        chk("mid_rst_code", 32'(show_code), 0);
        chk("mid_rst_level", 32'(level), 0);
        rst = 1'b0;
        tick();
        chk("post_rst_idle", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/button_seq_ctrl.md
BUTTON_SEQ_CTRL -- requirements
Module: button_seq_ctrl

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16: maximum sequence length, range 2..31.
REQ-002 SHALL have parameter SHOW_CYCLES, default 25_000_000: cycles each element is displayed.
REQ-003 SHALL have parameter GAP_CYCLES, default 12_500_000: blank cycles after each displayed element.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 250_000_000: maximum idle cycles between player presses.
REQ-005 SHALL have port clk, input, 1: clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port start, input, 1: level-sampled request to begin a game.
REQ-008 SHALL have port rand_in, input, 4: button code from the random generator; legal codes 0..5 (UP, DOWN, RIGHT, LEFT, A, B).
REQ-009 SHALL have port btn_valid, input, 1: single-cycle player-press strobe.
REQ-010 SHALL have port btn_code, input, 4: code of the pressed button, qualified by btn_valid.
REQ-011 SHALL have port show_valid, output, 1: high while an element is displayed.
REQ-012 SHALL have port show_code, output, 4: element being displayed; 0 when show_valid is low.
REQ-013 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-014 SHALL have port pass, output, 1: one-cycle pulse when a round is completed correctly.
REQ-015 SHALL have port fail, output, 1: one-cycle pulse on wrong press or timeout.
REQ-016 SHALL have port won, output, 1: high in WIN state.
REQ-017 SHALL have port level, output, 5: current sequence length.

Function
REQ-018 SHALL implement FSM states IDLE, GROW, SHOW, GAP, INPUT, PASS, FAIL, WIN.
REQ-019 IDLE: start=1 -> level cleared to 0, next state GROW; start is ignored in all other states.
REQ-020 GROW: rand_in<=5 -> store at seq[level], level+1, element index cleared, next SHOW; rand_in>5 -> remain in GROW, no store.
REQ-021 SHOW: show_valid=1, show_code=seq[idx], for exactly SHOW_CYCLES cycles, then GAP.
REQ-022 GAP: show_valid=0 for exactly GAP_CYCLES cycles; then idx+1 and SHOW if idx<level-1, else idx cleared, timer cleared, INPUT.
REQ-023 INPUT: btn_valid with btn_code==seq[idx] -> timer cleared; idx==level-1 -> PASS, else idx+1.
REQ-024 INPUT: btn_valid with btn_code!=seq[idx] -> FAIL; no TIMEOUT_CYCLES consecutive cycles without btn_valid -> FAIL.
REQ-025 INPUT: btn_valid on the cycle the timeout expires is evaluated as a press; the timeout does not fire.
REQ-026 btn_valid outside INPUT SHALL be ignored, with no state or counter effect.
REQ-027 PASS: pass=1 for one cycle; then WIN if level==MAX_LEN, else GROW.
REQ-028 FAIL: fail=1 for one cycle; then IDLE; level holds its value until the next start.
REQ-029 WIN: won=1; start=1 -> level cleared, GROW; otherwise remain in WIN.
REQ-030 Sequence storage SHALL be MAX_LEN x 3 bits; stored codes are rand_in[2:0].
REQ-031 Outputs pass, fail, busy, show_valid and show_code SHALL be registered or derived solely from state registers, with no combinational path from inputs.
REQ-032 Timer SHALL be wide enough for max(SHOW_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES) and SHALL never wrap.

Reset
REQ-033 rst SHALL force IDLE, level=0, idx=0, timer=0, all outputs 0; rst has priority over every other input, including mid-SHOW and mid-INPUT.
REQ-034 Sequence storage contents need not be reset.

Structure
REQ-035 Button code constants and the state enum SHALL reside in shared package btn_pkg.
REQ-036 Down-counter sub-module cycle_timer (load, count, done) SHALL implement the SHOW, GAP and timeout intervals.
REQ-037 The random generator SHALL be instantiated outside this block and drive rand_in.

Verification (SHOW_CYCLES=4, GAP_CYCLES=2, TIMEOUT_CYCLES=20, MAX_LEN=3)
REQ-038 start with rand_in=2 -> busy next cycle; show_valid high exactly 4 cycles with show_code=2; level=1.
REQ-039 Level 1 with seq={2}: press 2 -> pass pulse 1 cycle; GROW follows; level=2.
REQ-040 INPUT with seq[0]=2: press 4 -> fail pulse, then IDLE, busy=0.
REQ-041 INPUT: 20 cycles with no press -> fail; press exactly on cycle 20 -> accepted, no fail.
REQ-042 Three correct rounds -> won=1 and level=3; then start -> level=1.
REQ-043 rst asserted mid-SHOW -> next cycle IDLE, show_valid=0, level=0; rand_in=7 held in GROW -> no advance until a legal code arrives.
